// File: rtl/argmax_layer.sv
// Serial argmax over a latched vector of signed fixed-point logits, one compare per cycle.
// Define ARGMAX_MAX_VAL_EN to add the max_o port carrying the winning logit value.
module argmax_layer #(
  parameter int WORD_SIZE   = 16,
  parameter int OUTPUT_SIZE = 10,
  parameter int INDEX_BITS  = (OUTPUT_SIZE > 1) ? $clog2(OUTPUT_SIZE) : 1
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic [OUTPUT_SIZE*WORD_SIZE-1:0] data_i,
  input  logic                             valid_i,
  output logic                             yumi_o,
  output logic                             valid_o,
  input  logic                             ready_i,
  output logic [INDEX_BITS-1:0]            class_o
`ifdef ARGMAX_MAX_VAL_EN
  ,
  output logic signed [WORD_SIZE-1:0]      max_o
`endif
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;

  localparam bit                    SINGLE    = (OUTPUT_SIZE == 1);
  localparam logic [INDEX_BITS-1:0] LAST_IDX  = INDEX_BITS'(OUTPUT_SIZE - 1);
  localparam logic [INDEX_BITS-1:0] FIRST_CNT = SINGLE ? '0 : INDEX_BITS'(1);

  state_e                       state_q;
  logic signed [WORD_SIZE-1:0]  vec_q [OUTPUT_SIZE];
  logic signed [WORD_SIZE-1:0]  best_q, best_d;
  logic signed [WORD_SIZE-1:0]  cur_elem, elem0;
  logic [INDEX_BITS-1:0]        best_idx_q, best_idx_d;
  logic [INDEX_BITS-1:0]        cnt_q;
  logic [INDEX_BITS-1:0]        class_q;
  logic                         valid_q;
`ifdef ARGMAX_MAX_VAL_EN
  logic signed [WORD_SIZE-1:0]  max_q;
`endif

  assign elem0 = data_i[WORD_SIZE-1:0];

  generate
    if (OUTPUT_SIZE > 1) begin : g_sel
      assign cur_elem = vec_q[cnt_q];
    end else begin : g_one
      assign cur_elem = vec_q[0];
    end
  endgenerate

  always_comb begin
    // NOTE: defaults first, so every path assigns both outputs and no latch is inferred.
    best_d     = best_q;
    best_idx_d = best_idx_q;
    // Strict compare keeps the earlier index on ties.
    if (cur_elem > best_q) begin
      best_d     = cur_elem;
      best_idx_d = cnt_q;
    end
  end

  assign yumi_o = valid_i & ~reset_i &
                  ((state_q == IDLE) | ((state_q == DONE) & ready_i));

  // NOTE: all state here is sequential and uses non-blocking assignments only.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      valid_q    <= 1'b0;
      class_q    <= '0;
      best_q     <= '0;
      best_idx_q <= '0;
      cnt_q      <= '0;
      // NOTE: the vector store is small and must come up cleared, so it is reset like any register.
      for (int k = 0; k < OUTPUT_SIZE; k++) vec_q[k] <= '0;
`ifdef ARGMAX_MAX_VAL_EN
      max_q      <= '0;
`endif
    end else if (yumi_o) begin
      for (int k = 0; k < OUTPUT_SIZE; k++) vec_q[k] <= data_i[k*WORD_SIZE +: WORD_SIZE];
      best_q     <= elem0;
      best_idx_q <= '0;
      cnt_q      <= FIRST_CNT;
      valid_q    <= SINGLE;
      if (SINGLE) begin
        state_q <= DONE;
        class_q <= '0;
`ifdef ARGMAX_MAX_VAL_EN
        max_q   <= elem0;
`endif
      end else begin
        state_q <= SCAN;
      end
    end else begin
      case (state_q)
        IDLE: ;
        SCAN: begin
          best_q     <= best_d;
          best_idx_q <= best_idx_d;
          if (cnt_q == LAST_IDX) begin
            state_q <= DONE;
            valid_q <= 1'b1;
            class_q <= best_idx_d;
`ifdef ARGMAX_MAX_VAL_EN
            max_q   <= best_d;
`endif
          end else begin
            cnt_q <= cnt_q + INDEX_BITS'(1);
          end
        end
        DONE: begin
          if (ready_i) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign valid_o = valid_q;
  assign class_o = class_q;
`ifdef ARGMAX_MAX_VAL_EN
  assign max_o   = max_q;
`endif

endmodule
